// File: rtl/log_uart_tx.sv
// Drains 32-bit words from a logger FIFO and sends each as four 8N1 UART bytes,
// least significant byte first.
module log_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_read_data,
  output logic        read_enable,
  output logic        tx,
  output logic        busy,
  output logic        word_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [1:0]        byte_q, byte_d;
  logic [31:0]       shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              word_done_q, word_done_d;
  logic              armed_q, armed_d;
  logic              baud_end;

  assign baud_end  = (baud_q == BAUD_LAST);
  assign tx        = tx_q;
  assign word_done = word_done_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      word_done_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      word_done_q <= word_done_d;
      armed_q     <= armed_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    shift_d     = shift_q;
    word_done_d = 1'b0;
    armed_d     = 1'b1;
    read_enable = 1'b0;

    unique case (state_q)
      IDLE: begin
        // armed_q holds off the first fetch by one edge after reset release
        if (armed_q && !fifo_empty) state_d = FETCH;
      end
      FETCH: begin
        read_enable = 1'b1;
        state_d     = LOAD;
      end
      LOAD: begin
        shift_d = fifo_read_data;
        byte_d  = '0;
        bit_d   = '0;
        baud_d  = '0;
        state_d = START;
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[31:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else bit_d = bit_q + 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_q == 2'd3) begin
            word_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            byte_d  = byte_q + 1'b1;
            state_d = START;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next state so it lines up with state_q
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_log_uart_tx.sv
// Bench for log_uart_tx: FIFO model, byte scoreboard and a UART receiver model.
module tb_log_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        fifo_empty;
  logic [31:0] fifo_read_data;
  logic        read_enable;
  logic        tx;
  logic        busy;
  logic        word_done;

  int checks = 0;
  int failures = 0;

  logic [31:0] fifo_q[$];
  logic [7:0]  exp_q[$];
  logic        hold_empty = 1'b0;

  log_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty),
    .fifo_read_data(fifo_read_data), .read_enable(read_enable),
    .tx(tx), .busy(busy), .word_done(word_done)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears the cycle after the pop request
  always @(posedge clk) begin
    if (reset && read_enable && fifo_q.size() > 0) fifo_read_data <= fifo_q.pop_front();
  end
  always @(negedge clk) fifo_empty = hold_empty || (fifo_q.size() == 0);

  // UART receiver: every cycle of every bit must hold the bit's value
  logic       rx_ok, rx_abort;
  logic [7:0] rx_byte, rx_exp;
  always begin
    @(negedge clk);
    if (reset === 1'b1 && tx === 1'b0) begin
      rx_ok = 1'b1; rx_abort = 1'b0; rx_byte = 8'h00;
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < CPB; c++) begin
          if (!(b == 0 && c == 0)) @(negedge clk);
          if (reset !== 1'b1) rx_abort = 1'b1;
          else if (!rx_abort) begin
            if (b == 0 && tx !== 1'b0) rx_ok = 1'b0;
            if (b == 9 && tx !== 1'b1) rx_ok = 1'b0;
            if (b >= 1 && b <= 8) begin
              if (c == 0) rx_byte[b-1] = tx;
              else if (tx !== rx_byte[b-1]) rx_ok = 1'b0;
            end
          end
        end
      end
      if (!rx_abort) begin
        checks++;
        if (rx_ok !== 1'b1) begin
          failures++;
          $display("FAIL rx_framing: byte=%02h framing_ok=%0b required 1", rx_byte, rx_ok);
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rx_unexpected: got byte %02h, required no byte", rx_byte);
        end else begin
          rx_exp = exp_q.pop_front();
          if (rx_byte !== rx_exp) begin
            failures++;
            $display("FAIL rx_byte: got %02h required %02h", rx_byte, rx_exp);
          end else $display("rx byte %02h ok", rx_byte);
        end
      end
    end
  end

  task automatic push_word(input logic [31:0] w, input int nbytes);
    fifo_q.push_back(w);
    for (int i = 0; i < nbytes; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    fifo_read_data = 32'h0;
    fifo_empty = 1'b1;
    repeat (3) @(negedge clk);
    checks += 4;
    if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b required 1", tx); end
    if (read_enable !== 1'b0) begin failures++; $display("FAIL reset_rd: got %b required 0", read_enable); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (word_done !== 1'b0) begin failures++; $display("FAIL reset_wd: got %b required 0", word_done); end
    $display("test_reset done");
  endtask

  task automatic test_single_word();
    int rd_at, k, extra_rd, busy_drop;
    push_word(32'hA5C30F81, 4);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rd_at = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (read_enable === 1'b1) begin rd_at = i; break; end
    end
    checks++;
    if (rd_at < 2) begin
      failures++; $display("FAIL first_fetch: read_enable after %0d edges required >=2", rd_at);
    end
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL fetch_tx: got %b required 1", tx); end
    @(negedge clk);
    checks += 2;
    if (tx !== 1'b1) begin failures++; $display("FAIL load_tx: got %b required 1", tx); end
    if (read_enable !== 1'b0) begin failures++; $display("FAIL rd_width: got %b required 0", read_enable); end
    @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin failures++; $display("FAIL start_latency: tx=%b required 0", tx); end
    k = -1; extra_rd = 0; busy_drop = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (read_enable === 1'b1) extra_rd++;
      if (word_done === 1'b1) begin k = i; break; end
      if (busy !== 1'b1) busy_drop++;
    end
    checks += 3;
    if (k != 40 * CPB) begin failures++; $display("FAIL word_done_time: got %0d cycles required %0d", k, 40 * CPB); end
    if (extra_rd != 0) begin failures++; $display("FAIL single_rd_count: extra %0d required 0", extra_rd); end
    if (busy_drop != 0) begin failures++; $display("FAIL single_busy: low %0d cycles required 0", busy_drop); end
    @(negedge clk);
    checks += 2;
    if (word_done !== 1'b0) begin failures++; $display("FAIL wd_width: got %b required 0", word_done); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL single_bytes: %0d missing required 0", exp_q.size()); end
    $display("test_single_word done: word_done after %0d cycles", k);
  endtask

  task automatic test_back_to_back();
    int rd_cnt, wd_cnt, run, gap_run, idle_cnt;
    push_word(32'h00000000, 4);
    push_word(32'hFFFFFFFF, 4);
    rd_cnt = 0; wd_cnt = 0; run = 0; gap_run = -1; idle_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (read_enable === 1'b1) rd_cnt++;
      if (word_done === 1'b1) wd_cnt++;
      if (rd_cnt == 1 && busy !== 1'b1) idle_cnt++;
      if (tx === 1'b1) run++;
      else begin
        if (wd_cnt == 1 && gap_run < 0) gap_run = run;
        run = 0;
      end
      if (wd_cnt == 2) break;
    end
    repeat (3) @(negedge clk);
    checks += 5;
    if (rd_cnt != 2) begin failures++; $display("FAIL b2b_rd: got %0d required 2", rd_cnt); end
    if (wd_cnt != 2) begin failures++; $display("FAIL b2b_wd: got %0d required 2", wd_cnt); end
    if (gap_run != CPB + 3) begin failures++; $display("FAIL b2b_gap: high run %0d required %0d", gap_run, CPB + 3); end
    if (idle_cnt != 1) begin failures++; $display("FAIL b2b_idle: busy low %0d required 1", idle_cnt); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_bytes: %0d missing required 0", exp_q.size()); end
    $display("test_back_to_back done: gap run %0d", gap_run);
  endtask

  task automatic test_empty();
    int bad_rd, bad_tx, bad_busy;
    bad_rd = 0; bad_tx = 0; bad_busy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (read_enable !== 1'b0) bad_rd++;
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
    end
    checks += 3;
    if (bad_rd != 0) begin failures++; $display("FAIL empty_rd: %0d cycles required 0", bad_rd); end
    if (bad_tx != 0) begin failures++; $display("FAIL empty_tx: %0d low cycles required 0", bad_tx); end
    if (bad_busy != 0) begin failures++; $display("FAIL empty_busy: %0d cycles required 0", bad_busy); end
    $display("test_empty done");
  endtask

  task automatic test_empty_toggle();
    int rd_cnt, wd_cnt;
    logic seen;
    push_word(32'h3C3C1234, 4);
    push_word(32'hDEADBEEF, 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (read_enable === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL toggle_fetch: no read_enable required 1"); end
    rd_cnt = 1; wd_cnt = 0;
    repeat (10) @(negedge clk);
    hold_empty = 1'b1;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      if (read_enable === 1'b1) rd_cnt++;
      if (word_done === 1'b1) wd_cnt++;
    end
    checks += 3;
    if (rd_cnt != 1) begin failures++; $display("FAIL toggle_rd: got %0d required 1", rd_cnt); end
    if (wd_cnt != 1) begin failures++; $display("FAIL toggle_wd: got %0d required 1", wd_cnt); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL toggle_bytes: %0d missing required 0", exp_q.size()); end
    fifo_q.delete();
    hold_empty = 1'b0;
    repeat (2) @(negedge clk);
    $display("test_empty_toggle done");
  endtask

  task automatic test_reset_mid_frame();
    int bad_tx, bad_rd, bad_wd;
    logic seen;
    push_word(32'h12345678, 1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (read_enable === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL mid_fetch: no read_enable required 1"); end
    repeat (2) @(negedge clk);
    // now in the first start-bit cycle; byte 1 bit 3 covers cycles 56..59
    repeat (57) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin failures++; $display("FAIL mid_bit3: tx=%b required 0", tx); end
    #1 reset = 1'b0;
    #1;
    checks += 3;
    if (tx !== 1'b1) begin failures++; $display("FAIL mid_reset_tx: got %b required 1", tx); end
    if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy: got %b required 0", busy); end
    if (word_done !== 1'b0) begin failures++; $display("FAIL mid_reset_wd: got %b required 0", word_done); end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    bad_tx = 0; bad_rd = 0; bad_wd = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (read_enable !== 1'b0) bad_rd++;
      if (word_done !== 1'b0) bad_wd++;
    end
    checks += 4;
    if (bad_tx != 0) begin failures++; $display("FAIL post_reset_tx: %0d low cycles required 0", bad_tx); end
    if (bad_rd != 0) begin failures++; $display("FAIL post_reset_rd: %0d cycles required 0", bad_rd); end
    if (bad_wd != 0) begin failures++; $display("FAIL post_reset_wd: %0d cycles required 0", bad_wd); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL mid_bytes: %0d missing required 0", exp_q.size()); end
    $display("test_reset_mid_frame done");
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_empty();
    test_empty_toggle();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
